// File: rtl/pb_debounce_pkg.sv
// Shared constants, channel state encoding and width helper for the
// multi-channel push-button debouncer.
package pb_debounce_pkg;

   localparam int TICK_1MS_AT_50MHZ    = 50000;
   localparam int DEFAULT_CH           = 4;
   localparam int DEFAULT_STABLE_TICKS = 8;
   localparam int DEFAULT_SYNC_STAGES  = 2;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } ch_state_t;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: input synchroniser, stability counter, two-state FSM,
// registered level and one-clock press/release strobes.
module debounce_channel
   import pb_debounce_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic press_stb,
   output logic release_stb
);

   localparam int CNT_W = clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   ch_state_t              state;
   logic [CNT_W-1:0]       cnt;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], btn};
   end

   // A mismatch seen on a tick may be accepted straight from STABLE,
   // which matters when only one tick of stability is required.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_STABLE;
         cnt         <= '0;
         level       <= 1'b0;
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
      end else begin
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
         case (state)
            ST_STABLE: begin
               if (s == level) begin
                  cnt <= '0;
               end else if (tick && cnt == CNT_LAST) begin
                  level       <= s;
                  press_stb   <= s;
                  release_stb <= ~s;
                  cnt         <= '0;
               end else begin
                  state <= ST_PENDING;
                  if (tick) cnt <= cnt + 1'b1;
               end
            end
            ST_PENDING: begin
               if (s == level) begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end else if (tick && cnt == CNT_LAST) begin
                  state       <= ST_STABLE;
                  level       <= s;
                  press_stb   <= s;
                  release_stb <= ~s;
                  cnt         <= '0;
               end else if (tick) begin
                  cnt <= cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/pb_debounce_multi.sv
// Multi-channel push-button debouncer: one shared sample-tick divider
// feeding CH independent debounce channels.
module pb_debounce_multi
   import pb_debounce_pkg::*;
#(
   parameter int CH           = DEFAULT_CH,
   parameter int CLK_DIV      = TICK_1MS_AT_50MHZ,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] btn_in,
   output logic [CH-1:0] btn_level,
   output logic [CH-1:0] btn_press,
   output logic [CH-1:0] btn_release,
   output logic          tick
);

   localparam int DIV_W = clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   // tick is registered, so the first one lands CLK_DIV clocks after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick    <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
         tick    <= 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         tick    <= 1'b0;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .SYNC_STAGES  (SYNC_STAGES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .tick        (tick),
         .btn         (btn_in[i]),
         .level       (btn_level[i]),
         .press_stb   (btn_press[i]),
         .release_stb (btn_release[i])
      );
   end

endmodule

// File: tb/tb_pb_debounce_multi.sv
// Directed self-checking bench for pb_debounce_multi with CH=2, CLK_DIV=4,
// STABLE_TICKS=3, SYNC_STAGES=2 (clean-edge latency 11..14 clocks).
module tb_pb_debounce_multi;

   logic       clk;
   logic       rst_n;
   logic [1:0] btn_in;
   logic [1:0] btn_level;
   logic [1:0] btn_press;
   logic [1:0] btn_release;
   logic       tick;

   int checks = 0;
   int failures = 0;
   int press_cnt [2];
   int rel_cnt [2];
   int both_cnt = 0;
   int lat;
   int n;

   pb_debounce_multi #(
      .CH           (2),
      .CLK_DIV      (4),
      .STABLE_TICKS (3),
      .SYNC_STAGES  (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .tick        (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_range(input string tag, input int observed, input int lo, input int hi);
      checks++;
      assert (observed >= lo && observed <= hi) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d..%0d", tag, observed, lo, hi);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] value);
      btn_in = value;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 2; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
   endtask

   // Advance one clock and sample #1 after the edge, tallying strobes.
   task automatic step_clk();
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (btn_press[i] === 1'b1) press_cnt[i]++;
         if (btn_release[i] === 1'b1) rel_cnt[i]++;
         if (btn_press[i] === 1'b1 && btn_release[i] === 1'b1) both_cnt++;
      end
   endtask

   task automatic wait_level(input int ch, input logic value, output int cycles);
      cycles = 0;
      while (btn_level[ch] !== value && cycles < 40) begin
         step_clk();
         cycles++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(2'b11);
      clear_counts();

      $display("[TB] reset and tick divider");
      repeat (3) step_clk();
      checkOutput("reset_level", btn_level, 2'b00);
      checkOutput("reset_press", btn_press, 2'b00);
      checkOutput("reset_release", btn_release, 2'b00);
      checkOutput("reset_tick", tick, 1'b0);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step_clk();
         checkOutput($sformatf("tick_after_%0d", k), tick, (k % 4 == 0));
      end
      checkOutput("held_still_pending", btn_level, 2'b00);
      repeat (5) step_clk();
      checkOutput("held_accept_level", btn_level, 2'b11);
      checkOutput("held_accept_press", btn_press, 2'b11);
      step_clk();
      checkOutput("held_press_one_clk", btn_press, 2'b00);
      applyStimulus(2'b00);
      wait_level(0, 1'b0, lat);
      check_range("both_release_lat", lat, 11, 14);
      checkOutput("both_release_strobe", btn_release, 2'b11);
      step_clk();
      checkOutput("both_release_one_clk", btn_release, 2'b00);

      $display("[TB] clean press on ch0");
      clear_counts();
      applyStimulus(2'b01);
      wait_level(0, 1'b1, lat);
      check_range("clean_press_lat", lat, 11, 14);
      checkOutput("clean_press_strobe", btn_press, 2'b01);
      repeat (5) step_clk();
      checkOutput("clean_press_count", press_cnt[0], 1);
      checkOutput("ch1_level_untouched", btn_level[1], 1'b0);
      checkOutput("ch1_press_untouched", press_cnt[1], 0);

      $display("[TB] bouncing ch0");
      applyStimulus(2'b00);
      wait_level(0, 1'b0, lat);
      clear_counts();
      for (int j = 0; j < 10; j++) begin
         applyStimulus({1'b0, (j % 2 == 0)});
         repeat (3) step_clk();
      end
      checkOutput("bounce_level_held", btn_level[0], 1'b0);
      applyStimulus(2'b01);
      wait_level(0, 1'b1, lat);
      check_range("bounce_settle_lat", lat, 11, 14);
      repeat (3) step_clk();
      checkOutput("bounce_press_count", press_cnt[0], 1);
      checkOutput("bounce_release_count", rel_cnt[0], 0);

      $display("[TB] short glitch on ch1");
      applyStimulus(2'b11);
      wait_level(1, 1'b1, lat);
      clear_counts();
      applyStimulus(2'b01);
      repeat (6) step_clk();
      applyStimulus(2'b11);
      repeat (20) step_clk();
      checkOutput("glitch_level_kept", btn_level[1], 1'b1);
      checkOutput("glitch_release_count", rel_cnt[1], 0);
      checkOutput("glitch_press_count", press_cnt[1], 0);
      applyStimulus(2'b01);
      wait_level(1, 1'b0, lat);
      check_range("post_glitch_full_lat", lat, 11, 14);
      checkOutput("post_glitch_release", btn_release, 2'b10);

      $display("[TB] simultaneous channels");
      applyStimulus(2'b00);
      wait_level(0, 1'b0, lat);
      step_clk();
      clear_counts();
      applyStimulus(2'b11);
      wait_level(0, 1'b1, lat);
      checkOutput("simul_level", btn_level, 2'b11);
      checkOutput("simul_press", btn_press, 2'b11);
      step_clk();
      checkOutput("simul_press_one_clk", btn_press, 2'b00);
      applyStimulus(2'b00);
      wait_level(0, 1'b0, lat);
      checkOutput("simul_release", btn_release, 2'b11);
      checkOutput("simul_release_level", btn_level, 2'b00);

      $display("[TB] reset while pending");
      n = 0;
      while (tick !== 1'b1 && n < 8) begin
         step_clk();
         n++;
      end
      checkOutput("tick_found", tick, 1'b1);
      applyStimulus(2'b01);
      repeat (10) step_clk();
      checkOutput("pending_level", btn_level[0], 1'b0);
      rst_n = 1'b0;
      step_clk();
      checkOutput("midreset_level", btn_level, 2'b00);
      checkOutput("midreset_press", btn_press, 2'b00);
      checkOutput("midreset_tick", tick, 1'b0);
      rst_n = 1'b1;
      clear_counts();
      wait_level(0, 1'b1, lat);
      checkOutput("post_reset_lat", lat, 13);
      checkOutput("post_reset_press", btn_press, 2'b01);
      checkOutput("post_reset_press_count", press_cnt[0], 1);
      checkOutput("never_both_strobes", both_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pb_debounce_multi.md
Name: pb_debounce_multi

Overview:
Multi-channel push-button debouncer with integrated input synchronisers and a shared sample-tick divider. It is the parametrised successor to the single-button 1 ms debouncer. Channel count, tick period, stability window and synchroniser depth are all configurable. It adds one-cycle press/release strobes alongside the debounced level. It sits between raw board buttons/switches and control logic: CPU step/run controls, mode select, etc.

Parameters:
CH, 4, number of independent button channels (1..32)
CLK_DIV, 50000, clk cycles per sample tick (>=2); 50000 at 50 MHz gives 1 ms
STABLE_TICKS, 8, consecutive ticks a new value must persist before it is accepted (>=1)
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_in  input  CH  raw, asynchronous button inputs
btn_level  output  CH  debounced level per channel
btn_press  output  CH  one-clk strobe on debounced 0->1
btn_release  output  CH  one-clk strobe on debounced 1->0
tick  output  1  sample-tick strobe, exposed for observation and reuse

Behaviour:
- Reset is asynchronous and active-low; one clock, clk. All flops clear on rst_n=0:
  - synchronisers, div_cnt, per-channel counters -> 0
  - btn_level, btn_press, btn_release, tick -> 0
- Reset asserted mid-operation aborts any pending transition immediately. The first tick after release occurs CLK_DIV cycles later.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops to give s[i] (latency SYNC_STAGES clks).
- Tick divider:
  - div_cnt counts 0..CLK_DIV-1, then wraps to 0.
  - tick is a registered output, high for exactly one clk when div_cnt wraps, i.e. once every CLK_DIV clks.
  - Width is clog2(CLK_DIV).
- Per-channel FSM, two states:
  - STABLE: s==level; cnt held at 0.
  - PENDING: s!=level.
- Per-channel rules, evaluated every clk:
  - If s==level: cnt<=0; state STABLE. This applies on any cycle, tick or not, so a glitch shorter than a tick interval that returns to level still cancels.
  - Else, on tick with cnt<STABLE_TICKS-1: cnt<=cnt+1.
  - Else, on tick with cnt==STABLE_TICKS-1: level<=s, cnt<=0, and on the same edge press<=s or release<=~s.
  - Else (no tick): hold.
- Strobes:
  - press/release are high for exactly one clk, coincident with the first cycle of the new level.
  - Otherwise they are 0. press and release are never both high on one channel.
- Counter width: clog2(STABLE_TICKS+1); it never exceeds STABLE_TICKS-1.
- Latency from a clean input edge to level change is SYNC_STAGES+(STABLE_TICKS-1)*CLK_DIV+1 to SYNC_STAGES+STABLE_TICKS*CLK_DIV clks, depending on tick phase.
- STABLE_TICKS=1: the change is accepted on the first tick at which s differs from level.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.

Decomposition:
- Shared package pb_debounce_pkg:
  - clog2 function
  - default constants: tick-rate constant for the 50 MHz board clock, DEFAULT_STABLE_TICKS=8, DEFAULT_SYNC_STAGES=2
  - channel state encoding (ST_STABLE, ST_PENDING)
- Sub-module debounce_channel: synchroniser, counter, FSM, level and strobes for one bit; takes the shared tick as input. Instantiated CH times by a generate loop.
- Top level: tick divider plus the generate loop.

Test Plan:
Common parameters: CH=2, CLK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2.
1. Reset: hold rst_n=0 with btn_in=2'b11 -> all outputs 0. Release rst_n -> tick pulses every 4 clks starting 4 clks after release.
2. Clean press: ch0 0->1 and held -> btn_level[0] rises 11..14 clks later. btn_press[0] is high for exactly 1 clk on that edge. Ch1 is unaffected.
3. Bounce: ch0 toggles 1/0 every 3 clks for 30 clks, then settles at 1 -> exactly one btn_press[0] pulse, at most 14 clks after settling. No release strobe.
4. Short glitch: ch1 at level 1 drops to 0 for 6 clks (spanning 1-2 ticks) -> btn_level[1] stays 1, no strobes, counter returns to 0.
5. Simultaneous: both channels 0->1 on the same clk -> both levels rise on the same edge. btn_press=2'b11 for 1 clk. Later both release -> btn_release=2'b11.
6. Reset mid-PENDING: ch0 pending with cnt=2, assert rst_n=0 for 1 clk -> level 0, no strobe. The input must again persist 3 full ticks after reset before acceptance.
